inpoutp_scan_ctrl: RTL

Sequencer that drives the 4-input combinational block (inputs A,B,C,D, output Z) through all 16 input vectors. It waits a programmable settle time per vector, samples Z, and assembles a 16-bit truth table. It also compares each sample against an expected table and reports a mismatch summary. It sits between the test/config logic and the combinational datapath, and is the only driver of A..D during a scan.

---
 rtl/inpoutp_scan_ctrl_pkg.sv | 27 ++
 rtl/inpoutp_scan_ctrl_if.sv | 34 +++
 rtl/inpoutp_vec_gen.sv | 13 +
 rtl/inpoutp_scan_ctrl.sv | 129 ++++++++++++
 4 files changed

// File: rtl/inpoutp_scan_ctrl_pkg.sv
// Shared definitions for the truth-table scan sequencer: state encodings, widths, result record.
// Imported by the controller, its interface and the vector generator.
package inpoutp_scan_ctrl_pkg;

    localparam int NUM_VEC = 16;
    localparam int VEC_W   = 4;
    localparam int CNT_W   = 5;

    typedef logic [VEC_W-1:0] vec_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_SAMPLE = 3'd3,
        ST_DONE   = 3'd4
    } state_e;

    // Everything the scan reports back; cleared together on start acceptance.
    typedef struct packed {
        logic [NUM_VEC-1:0] truth_table;
        logic               mismatch;
        logic [CNT_W-1:0]   mismatch_count;
        vec_t               first_fail_idx;
    } res_t;

endpackage

// File: rtl/inpoutp_scan_ctrl_if.sv
// Bundle between config/test logic plus the combinational block (master) and the scan controller (slave).
// master drives requests and Z; slave drives A..D and the scan results.
interface inpoutp_scan_ctrl_if;
    import inpoutp_scan_ctrl_pkg::*;

    logic               start;
    logic               abort;
    logic               gray_mode;
    logic [NUM_VEC-1:0] expected;
    logic               a_o;
    logic               b_o;
    logic               c_o;
    logic               d_o;
    logic               z_i;
    logic               busy;
    logic               done;
    logic [NUM_VEC-1:0] truth_table;
    logic               mismatch;
    logic [CNT_W-1:0]   mismatch_count;
    vec_t               first_fail_idx;

    modport master (
        output start, abort, gray_mode, expected, z_i,
        input  a_o, b_o, c_o, d_o, busy, done,
        input  truth_table, mismatch, mismatch_count, first_fail_idx
    );

    modport slave (
        input  start, abort, gray_mode, expected, z_i,
        output a_o, b_o, c_o, d_o, busy, done,
        output truth_table, mismatch, mismatch_count, first_fail_idx
    );

endinterface

// File: rtl/inpoutp_vec_gen.sv
// Maps a scan index to the applied input vector: straight binary, or reflected Gray code.
// Purely combinational, zero latency, no flow control.
module inpoutp_vec_gen
    import inpoutp_scan_ctrl_pkg::*;
(
    input  vec_t idx,
    input  logic gray,
    output vec_t vec
);

    assign vec = gray ? (idx ^ (idx >> 1)) : idx;

endmodule

// File: rtl/inpoutp_scan_ctrl.sv
// Walks A..D through all 16 vectors, samples Z after a settle window and builds the truth table plus mismatch summary.
// SETTLE_CYCLES+2 cycles per vector; start is ignored unless idle, abort returns to idle on the next edge.
module inpoutp_scan_ctrl
    import inpoutp_scan_ctrl_pkg::*;
#(
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    inpoutp_scan_ctrl_if.slave   bus
);

    localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYCLES - 1);
    localparam vec_t       LAST_IDX    = vec_t'(NUM_VEC - 1);

    state_e     state_q, state_d;
    vec_t       idx_q, idx_d;
    logic       gray_q, gray_d;
    logic [3:0] cnt_q, cnt_d;
    res_t       res_q, res_d;

    vec_t       cur_vec;
    logic       z_miss;
    logic       busy;

    inpoutp_vec_gen u_vec_gen (
        .idx  (idx_q),
        .gray (gray_q),
        .vec  (cur_vec)
    );

    assign z_miss = bus.z_i ^ bus.expected[cur_vec];

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        gray_d  = gray_q;
        cnt_d   = cnt_q;
        res_d   = res_q;

        unique case (state_q)
            ST_IDLE: begin
                // abort has priority over a coincident start
                if (bus.start && !bus.abort) begin
                    state_d = ST_DRIVE;
                    idx_d   = '0;
                    gray_d  = bus.gray_mode;
                    cnt_d   = '0;
                    res_d   = '0;
                end
            end

            ST_DRIVE: begin
                cnt_d   = '0;
                state_d = bus.abort ? ST_IDLE : ST_SETTLE;
            end

            ST_SETTLE: begin
                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (cnt_q == SETTLE_LAST) begin
                    state_d = ST_SAMPLE;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end

            ST_SAMPLE: begin
                // Capture happens even when abort arrives in this cycle.
                res_d.truth_table[cur_vec] = bus.z_i;
                if (z_miss) begin
                    res_d.mismatch_count = res_q.mismatch_count + CNT_W'(1);
                    if (res_q.mismatch_count == '0) begin
                        res_d.first_fail_idx = cur_vec;
                    end
                end

                if (bus.abort) begin
                    state_d = ST_IDLE;
                end else if (idx_q == LAST_IDX) begin
                    state_d        = ST_DONE;
                    res_d.mismatch = (res_d.mismatch_count != '0);
                end else begin
                    idx_d   = idx_q + vec_t'(1);
                    state_d = ST_DRIVE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            gray_q  <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            gray_q  <= gray_d;
            cnt_q   <= cnt_d;
            res_q   <= res_d;
        end
    end

    // Outputs decode straight from flops so an async reset clears them without waiting for an edge.
    assign busy = (state_q == ST_DRIVE) || (state_q == ST_SETTLE) || (state_q == ST_SAMPLE);

    assign bus.busy           = busy;
    assign bus.done           = (state_q == ST_DONE);
    assign bus.a_o            = busy & cur_vec[3];
    assign bus.b_o            = busy & cur_vec[2];
    assign bus.c_o            = busy & cur_vec[1];
    assign bus.d_o            = busy & cur_vec[0];
    assign bus.truth_table    = res_q.truth_table;
    assign bus.mismatch       = res_q.mismatch;
    assign bus.mismatch_count = res_q.mismatch_count;
    assign bus.first_fail_idx = res_q.first_fail_idx;

endmodule
